keypad_scan_debounce: RTL
=========================

Name: keypad_scan_debounce

Overview:
Scans the 4x4 matrix keypad, debounces contacts and emits exactly one key event per physical press. It sits directly upstream of the operand-entry FSM in top_divisor. That FSM consumes key_value and key_valid: digits 0-9 are shifted into the BCD operands, and 'hA' commits an operand.
- Rows are driven active-low, one at a time.
- Columns are active-low with external pull-ups.

Parameters:
- ROW_DWELL, 27000, clocks each row is driven before its columns are sampled (1 ms at 27 MHz); minimum 4.
- STABLE_SCANS, 20, consecutive equal samples required to accept a press or a release; minimum 2.

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  synchronous, active-high reset
- filas  out  4  row drive, one-hot low; filas[i]=0 selects row i
- columnas  in  4  raw column inputs, asynchronous, active-low
- key_value  out  4  code of the last accepted key; held until the next accepted key
- key_valid  out  1  one-clk pulse when key_value updates
- key_held  out  1  high from the key_valid cycle until the release is accepted

Behaviour:
Outputs after reset: filas=4'b1110, key_value=0, key_valid=0, key_held=0.

Reset:
- A 1-cycle rst at any time returns to SCAN, row 0, with all counters cleared.
- No key_valid pulse is issued from a pending press.

Column input:
- columnas passes through a 2-FF synchronizer to give col_s.
- Only col_s is used.

Tick generator:
- Counter runs 0..ROW_DWELL-1.
- tick=1 in the cycle the counter equals ROW_DWELL-1; the counter then wraps to 0.
- All samples below are taken in tick cycles only.

Key map, as (row,col) -> code:
- Row 0: 1, 2, 3, A
- Row 1: 4, 5, 6, B
- Row 2: 7, 8, 9, C
- Row 3: *=E, 0=0, #=F, D=D

FSM:
- SCAN
  - Drives the current row.
  - On tick with col_s==4'hF: row <= row+1 (3 wraps to 0).
  - On tick with any col_s bit low: latch the row and the lowest-index low column, set cnt=1, go DEBOUNCE.
- DEBOUNCE
  - Row is frozen.
  - On tick with the latched column low: cnt++.
  - When cnt reaches STABLE_SCANS: set key_value=map(row,col) and key_valid=1 in the next cycle, set key_held=1, clear cnt, go HELD.
  - On tick with the latched column high: clear cnt, row <= row+1, go SCAN. No event is issued.
- HELD
  - Row is frozen. No auto-repeat.
  - On tick with the latched column high: rel_cnt++.
  - On tick with the latched column low: rel_cnt=0.
  - When rel_cnt reaches STABLE_SCANS: key_held=0, row <= row+1, go SCAN.

Press latency:
- key_valid rises 1 clk after the tick carrying the STABLE_SCANS-th consecutive low sample.
- That is (STABLE_SCANS-1)*ROW_DWELL+1 clocks after the detecting tick.

Multiple keys and ghosting:
- Only the latched (row,col) is tracked.
- Other keys pressed or released meanwhile are ignored.
- A second key still held after release of the first is detected normally by the next SCAN pass.

key_valid:
- Never high two consecutive cycles.
- At most one pulse per press.

Counter widths:
- The tick counter is $clog2(ROW_DWELL) bits.
- cnt and rel_cnt are $clog2(STABLE_SCANS+1) bits and saturate at no value; the FSM exits first.

Decomposition:
Package kbd_pkg holds:
- the kbd_state_t enum {SCAN, DEBOUNCE, HELD};
- key-code constants KEY_A..KEY_F, KEY_STAR=4'hE, KEY_HASH=4'hF;
- the function key_map(row,col) returning logic [3:0].

Sub-module kbd_tick_gen is the parameterized ROW_DWELL counter with a tick output and synchronous active-high reset. Synchronizer and FSM stay in keypad_scan_debounce.

Test Plan:
All tests use ROW_DWELL=8, STABLE_SCANS=3.
1. Idle after reset, columnas=4'hF for 100 clks:
   - filas cycles 1110, 1101, 1011, 0111, 1110, changing every 8 clks;
   - key_valid stays 0 and key_value=0.
2. Clean press of row 1 col 2 ('6'), held 200 clks, then released:
   - exactly one key_valid pulse with key_value=4'h6, (3-1)*8+1=17 clks after the detecting tick;
   - key_held=1 until 3 high ticks after release;
   - scanning then resumes at row 2.
3. Bounce on '5': low for 1 tick, high, then stable low:
   - no pulse from the first contact;
   - a single pulse with 4'h5 after 3 consecutive low ticks.
4. Hold 'A' (row 0 col 3) for 1000 clks:
   - one pulse with 4'hA; no repeat;
   - key_held stays high for the whole hold;
   - a 1-tick release glitch mid-hold produces no new pulse.
5. Press '1' and '2' simultaneously (row 0 cols 0 and 1):
   - a single pulse with 4'h1;
   - releasing '1' while keeping '2' gives a second pulse with 4'h2 on the next scan pass.
6. rst asserted for 1 clk mid-DEBOUNCE, while '0' (row 3 col 1) is held:
   - filas=1110 and no pulse from the interrupted debounce;
   - '0' is re-detected on the row-3 visit, giving one pulse with 4'h0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared state type, key codes and the (row,col) -> code map
// for the 4x4 keypad scanner.
package kbd_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } kbd_state_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_E    = 4'hE;
    localparam logic [3:0] KEY_F    = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kbd_tick_gen.sv
// Row-dwell timer: free-running 0..ROW_DWELL-1 counter that
// flags the last cycle of each dwell period.
module kbd_tick_gen #(
    parameter int unsigned ROW_DWELL = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned W = $clog2(ROW_DWELL);
    localparam logic [W-1:0] LAST = W'(ROW_DWELL - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with per-key debounce; one key_valid
// pulse per accepted press, key_held until the release is accepted.
module keypad_scan_debounce #(
    parameter int unsigned ROW_DWELL    = 27000,
    parameter int unsigned STABLE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] filas,
    input  logic [3:0] columnas,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    import kbd_pkg::*;

    localparam int unsigned CW = $clog2(STABLE_SCANS + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_SCANS);

    logic [3:0]  col_m;
    logic [3:0]  col_s;
    logic        tick;
    kbd_state_t  state;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [1:0]  low_col;
    logic        col_bit;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rel_cnt;

    kbd_tick_gen #(
        .ROW_DWELL(ROW_DWELL)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Columns idle high (pull-ups), so the synchronizer resets to all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= columnas;
            col_s <= col_m;
        end
    end

    always_comb begin
        low_col = 2'd3;
        if (!col_s[0]) begin
            low_col = 2'd0;
        end else if (!col_s[1]) begin
            low_col = 2'd1;
        end else if (!col_s[2]) begin
            low_col = 2'd2;
        end
    end

    assign col_bit = col_s[col];
    assign filas   = ~(4'b0001 << row);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            rel_cnt   <= '0;
            key_value <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (col_s == 4'hF) begin
                            row <= row + 2'd1;
                        end else begin
                            col   <= low_col;
                            cnt   <= CW'(1);
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!col_bit) begin
                            if (cnt + CW'(1) == STABLE) begin
                                key_value <= key_map(row, col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt   <= '0;
                            row   <= row + 2'd1;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (col_bit) begin
                            if (rel_cnt + CW'(1) == STABLE) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                row      <= row + 2'd1;
                                state    <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + CW'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
